frame_stream_ctrl: RTL
======================

Name: frame_stream_ctrl

Overview:
- Frame-level sequencer placed in front of the line-buffer/convolution pipeline in the image processing top.
- Starts a frame on command and gates the input pixel stream into the pipeline.
- Counts columns and rows and throttles input when the output FIFO reports prog_full.
- Drains the pipeline after the last pixel, then raises line-done and frame-done interrupts.

Parameters:
- IMG_WIDTH, 512: pixels per line; must be ≥2.
- IMG_HEIGHT, 512: lines per frame; must be ≥2.
- DRAIN_CYCLES, 8: idle cycles after the last accepted pixel, allowing the pipeline to flush; must be ≥1.
- TIMEOUT_CYCLES, 65535: stall limit; used only with FRAME_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle frame start request
- i_abort  in  1  synchronous abort; returns to IDLE
- i_intr_clr  in  1  clears o_frame_intr
- i_pixel_valid  in  1  upstream pixel valid
- i_pixel_data  in  8  upstream pixel
- o_pixel_ready  out  1  upstream ready
- o_pixel_valid  out  1  pixel valid toward line buffers
- o_pixel_data  out  8  pixel toward line buffers
- i_fifo_prog_full  in  1  output FIFO almost-full
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse at frame end
- o_line_intr  out  1  one-cycle pulse per completed line
- o_frame_intr  out  1  sticky frame-complete interrupt
- o_col  out  $clog2(IMG_WIDTH)  current column
- o_row  out  $clog2(IMG_HEIGHT)  current row
- o_err  out  1  sticky timeout error; held 0 without FRAME_TIMEOUT_EN

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: i_start → ACCEPT; col and row cleared on entry.
  - ACCEPT: ends on transfer of the last pixel (col=W-1, row=H-1) → DRAIN.
  - DRAIN: lasts DRAIN_CYCLES cycles → DONE.
  - DONE: lasts exactly one cycle → IDLE.
- i_start outside IDLE is ignored.
- i_abort takes priority over every other event: next state IDLE, counters 0, o_pixel_valid 0, no o_done, no interrupts generated; o_frame_intr and o_err keep their values.
- o_pixel_ready = (state==ACCEPT) && !i_fifo_prog_full. This is combinational, with no registered lookahead.
- Transfer = i_pixel_valid && o_pixel_ready.
- Forward path is one registered stage:
  - o_pixel_valid <= transfer.
  - o_pixel_data <= i_pixel_data on transfer, otherwise holds its value.
  - Latency is 1 cycle; no pixel is dropped or duplicated.
- Counters:
  - col increments on each transfer.
  - At col=W-1, col wraps to 0 and row increments.
  - At row=H-1 with col=W-1, both wrap to 0.
  - Counters never advance without a transfer.
- o_line_intr pulses the cycle after each line-completing transfer, H pulses per frame. The last line's pulse coincides with the first DRAIN cycle.
- If prog_full asserts mid-line, ready drops in the same cycle and the counters freeze. Transfers resume when prog_full deasserts.
- DRAIN: o_pixel_ready=0. The counter runs regardless of prog_full.
- DONE: o_done=1 for one cycle; o_frame_intr set on the same edge.
- o_frame_intr clears only on i_intr_clr. If a set and a clear occur in the same cycle, the set wins.
- i_start in the same cycle as DONE→IDLE is ignored. The frame starts from IDLE on a later i_start.
- Asynchronous reset mid-frame: immediate return to all reset values, including the interrupt flags.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - A stall counter runs in ACCEPT; it clears on each transfer and on ACCEPT entry.
  - When it reaches TIMEOUT_CYCLES with no transfer, go to DONE and set o_err (sticky, cleared by i_intr_clr or reset).
  - o_done still pulses.
- FRAME_TIMEOUT_EN undefined:
  - No stall counter; o_err is tied to 0.
  - ACCEPT waits indefinitely.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, DRAIN_CYCLES=2, TIMEOUT_CYCLES=10):
- Start, then 12 pixels 0x01..0x0C with valid held high and prog_full=0 → ready high for 12 cycles; o_pixel_data 0x01..0x0C each one cycle after its transfer; o_line_intr pulses after pixels 4, 8 and 12; then 2 DRAIN cycles; o_done pulses 3 cycles after the last transfer; o_frame_intr=1.
- prog_full=1 for 5 cycles after pixel 6 → ready=0 in those same 5 cycles; col stays 2 and row stays 1; pixel 7 transfers on the first cycle with prog_full=0; output order is intact.
- i_abort asserted after pixel 5 → next cycle busy=0, col=0, row=0; no o_done; a fresh start then completes a full 12-pixel frame correctly.
- o_frame_intr=1 with i_intr_clr pulsed → o_frame_intr=0. i_intr_clr asserted in the DONE cycle of the next frame → o_frame_intr=1 (set wins).
- FRAME_TIMEOUT_EN: start, 3 pixels, then valid=0 → after 10 idle cycles o_done pulses, o_err=1, busy=0. Without the macro, the same stimulus leaves busy=1 and o_err=0 indefinitely.
- Async reset asserted mid-DRAIN → all outputs 0 immediately, asynchronous to i_clk.

Source files
------------

// File: rtl/frame_stream_ctrl.sv
`default_nettype none
// frame_stream_ctrl: frame sequencer that gates the pixel stream into the line-buffer pipeline.
// Optional stall timeout is enabled by defining FRAME_TIMEOUT_EN.
module frame_stream_ctrl #(
    parameter int IMG_WIDTH      = 512,
    parameter int IMG_HEIGHT     = 512,
    parameter int DRAIN_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_intr_clr,
    input  logic                          i_pixel_valid,
    input  logic [7:0]                    i_pixel_data,
    output logic                          o_pixel_ready,
    output logic                          o_pixel_valid,
    output logic [7:0]                    o_pixel_data,
    input  logic                          i_fifo_prog_full,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_line_intr,
    output logic                          o_frame_intr,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
    output logic                          o_err
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] drain_cnt;
    logic          transfer;
    logic          col_last;
    logic          row_last;
    logic          timeout;
    logic          frame_intr_set;

    assign o_pixel_ready = (state == ACCEPT) && !i_fifo_prog_full;
    assign transfer      = i_pixel_valid && o_pixel_ready;
    assign col_last      = (o_col == COL_LAST);
    assign row_last      = (o_row == ROW_LAST);
    assign o_busy        = (state != IDLE);

`ifdef FRAME_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0] stall_cnt;

    // Counts consecutive ACCEPT cycles without a transfer.
    assign timeout = (state == ACCEPT) && !transfer && (stall_cnt == STALL_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (state != ACCEPT || transfer) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (timeout && !i_abort) begin
            o_err <= 1'b1;
        end else if (i_intr_clr) begin
            o_err <= 1'b0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
    assign o_err          = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) state_next = ACCEPT;
            end
            ACCEPT: begin
                if (transfer && col_last && row_last) state_next = DRAIN;
                else if (timeout)                     state_next = DONE;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_abort) state_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_col <= '0;
            o_row <= '0;
        end else if (i_abort || (state == IDLE && i_start)) begin
            o_col <= '0;
            o_row <= '0;
        end else if (transfer) begin
            if (col_last) begin
                o_col <= '0;
                o_row <= row_last ? '0 : o_row + RW'(1);
            end else begin
                o_col <= o_col + CW'(1);
            end
        end
    end

    // The DONE cycle itself also counts as a set so a clear landing there loses.
    assign frame_intr_set = (state_next == DONE) || (state == DONE && !i_abort);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pixel_valid <= 1'b0;
            o_pixel_data  <= '0;
            o_line_intr   <= 1'b0;
            o_done        <= 1'b0;
            o_frame_intr  <= 1'b0;
        end else begin
            o_pixel_valid <= transfer && !i_abort;
            o_line_intr   <= transfer && col_last && !i_abort;
            o_done        <= (state_next == DONE);
            if (transfer) o_pixel_data <= i_pixel_data;
            if (frame_intr_set)  o_frame_intr <= 1'b1;
            else if (i_intr_clr) o_frame_intr <= 1'b0;
        end
    end
endmodule
`default_nettype wire
